instr_fetch_unit: RTL and testbench

- Upstream stage of the control unit. Holds the program counter (PC), the instruction memory and the instruction register (IR).
- Responds to the controller's PC_clr, PC_up and IR_ld strobes and presents the IR word that the controller decodes.
- Includes a boot-time program-load mode, so a testbench or loader can fill instruction memory before the core runs.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instr_mem.sv | 26 ++
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: default widths, FSM state type and
// the opcode encodings also used by the controller.
package fetch_pkg;

  localparam int AW_DEFAULT = 7;
  localparam int DW_DEFAULT = 16;

  localparam logic [15:0] FETCH_MAX = 16'hFFFF;

  typedef enum logic {LOAD, RUN} fetch_state_t;

  // OP_ prefix keeps OP_LOAD distinct from the LOAD state in this namespace.
  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port for the loader and one
// combinational read port addressed by the program counter.
module instr_mem #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // No reset on the array so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program-load FSM, program counter, instruction register and
// fetch statistics, all registered.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PC_clr,
  input  logic          PC_up,
  input  logic          IR_ld,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  input  logic          prog_done,
  output logic [DW-1:0] IR,
  output logic [AW-1:0] PC,
  output logic          ready,
  output logic [15:0]   fetch_count,
  output logic          pc_wrap
);

  fetch_state_t  state;
  logic [DW-1:0] rdata;
  logic          mem_we;

  // Memory becomes read-only once the core is running.
  assign mem_we = prog_we && (state == LOAD);

  instr_mem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (PC),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      PC          <= '0;
      IR          <= '0;
      ready       <= 1'b0;
      fetch_count <= '0;
      pc_wrap     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (prog_done) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
          // rdata reflects the pre-update PC, so a combined IR_ld+PC_up
          // captures instruction n while PC moves to n+1.
          if (IR_ld) begin
            IR <= rdata;
            if (fetch_count != FETCH_MAX) begin
              fetch_count <= fetch_count + 16'd1;
            end
          end
          if (PC_clr) begin
            PC <= '0;
          end else if (PC_up) begin
            PC <= PC + AW'(1);
            if (&PC) begin
              pc_wrap <= 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver advances a behavioural
// model and queues expected outputs; a monitor compares after every edge.
module tb_instr_fetch_unit;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int DEPTH = 128;

  logic          clk;
  logic          rst;
  logic          PC_clr;
  logic          PC_up;
  logic          IR_ld;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          prog_done;
  logic [DW-1:0] IR;
  logic [AW-1:0] PC;
  logic          ready;
  logic [15:0]   fetch_count;
  logic          pc_wrap;

  instr_fetch_unit #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_clr      (PC_clr),
    .PC_up       (PC_up),
    .IR_ld       (IR_ld),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_done   (prog_done),
    .IR          (IR),
    .PC          (PC),
    .ready       (ready),
    .fetch_count (fetch_count),
    .pc_wrap     (pc_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] ir;
    logic [6:0]  pc;
    logic        rdy;
    logic [15:0] cnt;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  // Reference model, expressed as plain arithmetic on the specified rules
  int          m_pc;
  int          m_cnt;
  logic [15:0] m_ir;
  bit          m_run;
  bit          m_wrap;
  logic [15:0] m_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply the current inputs to the model, queue the expectation, take one edge.
  task automatic step();
    exp_t e;
    if (rst) begin
      m_pc = 0; m_ir = 16'h0; m_cnt = 0; m_run = 0; m_wrap = 0;
    end else if (!m_run) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      if (prog_done) m_run = 1;
    end else begin
      if (IR_ld) begin
        m_ir = m_mem[m_pc];
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (PC_clr) m_pc = 0;
      else if (PC_up) begin
        if (m_pc == DEPTH - 1) m_wrap = 1;
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
    e.ir = m_ir; e.pc = 7'(m_pc); e.rdy = m_run; e.cnt = 16'(m_cnt); e.wrap = m_wrap;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    PC_clr = 0; PC_up = 0; IR_ld = 0; prog_we = 0; prog_done = 0;
    prog_addr = '0; prog_data = '0;
  endtask

  // Monitor: one line per transaction, comparing every output against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        chk("ir", 32'(IR), 32'(e.ir));
        chk("pc", 32'(PC), 32'(e.pc));
        chk("ready", 32'(ready), 32'(e.rdy));
        chk("fetch_count", 32'(fetch_count), 32'(e.cnt));
        chk("pc_wrap", 32'(pc_wrap), 32'(e.wrap));
        if (txn <= 600)
          $display("txn %0d: PC=%0d IR=%h ready=%0b count=%0d wrap=%0b", txn, PC, IR, ready, fetch_count, pc_wrap);
      end
    end
  end

  initial begin
    int spins;
    idle();
    rst = 1;
    m_pc = 0; m_ir = 0; m_cnt = 0; m_run = 0; m_wrap = 0;
    step(); step();
    rst = 0;

    // Strobes must be ignored while loading
    PC_up = 1; IR_ld = 1;
    repeat (3) step();
    PC_clr = 1; step();
    idle();
    chk("load_ignore_pc", 32'(PC), 32'd0);
    chk("load_ignore_ir", 32'(IR), 32'd0);
    chk("load_ignore_ready", 32'(ready), 32'd0);

    // Fill memory; the final write coincides with prog_done
    for (int a = 0; a < DEPTH; a++) begin
      prog_we = 1; prog_addr = 7'(a);
      prog_data = (a == 0) ? 16'h3001 : (a == 1) ? 16'h4012 : (a == 2) ? 16'h2011 : 16'($urandom);
      prog_done = (a == DEPTH - 1);
      step();
    end
    idle();
    chk("ready_after_done", 32'(ready), 32'd1);

    // Two one-cycle fetches
    IR_ld = 1; PC_up = 1; step();
    chk("fetch1_ir", 32'(IR), 32'h3001);
    step();
    idle();
    chk("fetch2_ir", 32'(IR), 32'h4012);
    chk("fetch2_pc", 32'(PC), 32'd2);

    // Writes are locked out in RUN
    prog_we = 1; prog_addr = 0; prog_data = 16'hFFFF; step();
    idle(); PC_clr = 1; step();
    idle(); IR_ld = 1; step();
    idle();
    chk("lockout_ir", 32'(IR), 32'h3001);

    // Clear wins over increment
    PC_clr = 1; step(); idle();
    PC_up = 1; repeat (5) step(); idle();
    PC_clr = 1; PC_up = 1; step(); idle();
    chk("clr_prio_pc", 32'(PC), 32'd0);

    // Wrap and sticky flag
    PC_up = 1; repeat (127) step(); idle();
    chk("pre_wrap_flag", 32'(pc_wrap), 32'd0);
    PC_up = 1; step(); idle();
    chk("wrap_flag", 32'(pc_wrap), 32'd1);
    PC_clr = 1; step(); idle();
    chk("wrap_sticky", 32'(pc_wrap), 32'd1);

    // Async reset mid-run at PC=3, IR=mem[2]
    IR_ld = 1; PC_up = 1; repeat (3) step(); idle();
    chk("pre_rst_ir", 32'(IR), 32'h2011);
    chk("pre_rst_pc", 32'(PC), 32'd3);
    rst = 1;
    #1;
    chk("async_rst_pc", 32'(PC), 32'd0);
    chk("async_rst_ir", 32'(IR), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    step();
    rst = 0;
    prog_done = 1; step(); idle();
    IR_ld = 1; PC_up = 1; step(); idle();
    chk("retained_ir", 32'(IR), 32'h3001);

    // Randomized RUN traffic
    for (int i = 0; i < 400; i++) begin
      PC_clr = ($urandom_range(0, 7) == 0);
      PC_up = $urandom_range(0, 1) == 1;
      IR_ld = $urandom_range(0, 1) == 1;
      prog_we = $urandom_range(0, 3) == 0;
      prog_addr = 7'($urandom);
      prog_data = 16'($urandom);
      prog_done = $urandom_range(0, 7) == 0;
      step();
    end
    idle();

    // Drive the fetch counter into saturation
    IR_ld = 1;
    for (int i = 0; i < 65540; i++) begin
      PC_up = $urandom_range(0, 1) == 1;
      step();
    end
    idle();
    chk("count_saturated", 32'(fetch_count), 32'hFFFF);
    step();

    spins = 0;
    while (sb.size() > 0 && spins < 10) begin
      @(posedge clk);
      spins++;
    end
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
